// File: rtl/shift4_feeder.sv
// shift4_feeder
//   Buffers upstream words in a small FIFO and feeds them, one at a time,
//   to a downstream Shift4: a one-cycle load strobe with the parallel word,
//   followed by exactly `size` enabled shift cycles. `stall` pauses shifting.
//
// Ports
//   clk         single clock, rising edge
//   areset_n    asynchronous active-low reset
//   in_valid    upstream word valid
//   in_data     upstream word [size-1:0]
//   in_ready    FIFO can accept a word (not full)
//   stall       pause shifting (ignored in IDLE and LOAD)
//   sh_load     load strobe to Shift4 (registered)
//   sh_ena      shift enable to Shift4 (registered)
//   sh_data     parallel word to Shift4, held from pop to next pop (registered)
//   busy        high whenever the FSM is not IDLE (registered)
//   word_done   one-cycle pulse on the last enabled shift of a word (registered)
//   fifo_count  FIFO occupancy [$clog2(DEPTH):0]
module shift4_feeder #(
    parameter int size  = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic                     in_valid,
    input  logic [size-1:0]          in_data,
    output logic                     in_ready,
    input  logic                     stall,
    output logic                     sh_load,
    output logic                     sh_ena,
    output logic [size-1:0]          sh_data,
    output logic                     busy,
    output logic                     word_done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(size) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t             state, state_n;
    logic [size-1:0]    mem [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic               push, pop, has_word, last_shift;
    logic               load_n, ena_n, done_n, busy_n;
    logic [size-1:0]    data_n;
    logic [NW-1:0]      cnt, cnt_n, cnt_inc;

    assign in_ready = (fifo_count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign has_word = (fifo_count != '0);

    // cnt holds the number of enabled cycles issued before the current one;
    // the current cycle is the last one when it is enabled and cnt == size-1.
    assign cnt_inc    = cnt + NW'(sh_ena);
    assign last_shift = sh_ena && (cnt == NW'(size - 1));

    always_comb begin
        state_n = state;
        load_n  = 1'b0;
        ena_n   = 1'b0;
        done_n  = 1'b0;
        busy_n  = busy;
        data_n  = sh_data;
        cnt_n   = cnt;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (has_word) begin
                    pop     = 1'b1;
                    data_n  = mem[rptr];
                    load_n  = 1'b1;
                    busy_n  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                cnt_n   = '0;
                ena_n   = !stall;
                done_n  = !stall && (size == 1);
                state_n = SHIFT;
            end
            SHIFT: begin
                if (last_shift) begin
                    // Chain straight into the next word without an IDLE cycle.
                    if (has_word) begin
                        pop     = 1'b1;
                        data_n  = mem[rptr];
                        load_n  = 1'b1;
                        state_n = LOAD;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n  = cnt_inc;
                    ena_n  = !stall;
                    done_n = !stall && (cnt_inc == NW'(size - 1));
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sh_load   <= 1'b0;
            sh_ena    <= 1'b0;
            sh_data   <= '0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            cnt       <= '0;
        end else begin
            sh_load   <= load_n;
            sh_ena    <= ena_n;
            sh_data   <= data_n;
            busy      <= busy_n;
            word_done <= done_n;
            cnt       <= cnt_n;
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift4_feeder.sv
module tb_shift4_feeder;

    localparam int SIZE  = 4;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   areset_n;
    logic                   in_valid;
    logic [SIZE-1:0]        in_data;
    logic                   in_ready;
    logic                   stall;
    logic                   sh_load;
    logic                   sh_ena;
    logic [SIZE-1:0]        sh_data;
    logic                   busy;
    logic                   word_done;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;
    int accepted = 0;

    // Expected output words in acceptance order.
    logic [SIZE-1:0] exp_q[$];

    shift4_feeder #(.size(SIZE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall      (stall),
        .sh_load    (sh_load),
        .sh_ena     (sh_ena),
        .sh_data    (sh_data),
        .busy       (busy),
        .word_done  (word_done),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_sh_load"},    32'(sh_load),    0);
        check({tag, "_sh_ena"},     32'(sh_ena),     0);
        check({tag, "_sh_data"},    32'(sh_data),    0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_word_done"},  32'(word_done),  0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 0);
        check({tag, "_in_ready"},   32'(in_ready),   1);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_word(input logic [SIZE-1:0] d);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(d);
                accepted++;
                ok = 1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (!busy && fifo_count == 0 && exp_q.size() == 0) done = 1;
        end
        check({tag, "_drained"}, 32'(done), 1);
    endtask

    // Monitor: every load must present the next expected word, and every
    // word must receive exactly SIZE enabled cycles ending on word_done.
    logic [SIZE-1:0] cur;
    int              ena_seen;
    bit              in_word;

    initial begin
        cur = '0;
        ena_seen = 0;
        in_word = 0;
    end

    always @(negedge clk) begin
        if (!areset_n) begin
            in_word  = 0;
            ena_seen = 0;
        end else begin
            if (sh_load) begin
                check("load_ena_exclusive", 32'(sh_ena), 0);
                check("prev_word_complete", 32'(in_word), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load actual=%0h required=no_load", sh_data);
                end else begin
                    check("load_data", 32'(sh_data), 32'(exp_q.pop_front()));
                end
                cur      = sh_data;
                in_word  = 1;
                ena_seen = 0;
            end
            if (sh_ena) begin
                ena_seen++;
                check("ena_in_word", 32'(in_word), 1);
                check("ena_data_hold", 32'(sh_data), 32'(cur));
            end
            if (word_done) begin
                check("done_with_ena", 32'(sh_ena), 1);
                check("ena_count", 32'(ena_seen), SIZE);
                in_word = 0;
            end
        end
    end

    initial begin
        int first_wd, second_ld, loads, busy_cnt;
        bit rs_done, full_seen;

        areset_n = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        stall    = 1'b0;

        // Power-on reset values
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        #2 areset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word timing
        push_word(4'b1011);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("single_load_k%0d", k), 32'(sh_load), 32'(k == 1));
            check($sformatf("single_ena_k%0d", k), 32'(sh_ena), 32'(k >= 2 && k <= 5));
            check($sformatf("single_done_k%0d", k), 32'(word_done), 32'(k == 5));
            check($sformatf("single_busy_k%0d", k), 32'(busy), 32'(k <= 5));
            if (k == 1) check("single_data", 32'(sh_data), 32'hB);
        end
        wait_idle("single");

        // Back-to-back words: no IDLE gap, 10 busy cycles
        @(posedge clk);
        #1;
        push_word(4'b0001);
        push_word(4'b1110);
        first_wd = -1; second_ld = -1; loads = 0; busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (word_done && first_wd < 0) first_wd = i;
            if (sh_load) begin
                loads++;
                if (loads == 2) second_ld = i;
            end
        end
        check("b2b_no_gap", 32'(second_ld), 32'(first_wd + 1));
        check("b2b_busy_cycles", 32'(busy_cnt), 10);
        wait_idle("b2b");

        // Stall for 3 cycles after the second enabled shift
        @(posedge clk);
        #1;
        push_word(4'($urandom));
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            if (k == 3) begin #1; stall = 1'b1; end
            if (k == 6) begin #1; stall = 1'b0; end
            @(negedge clk);
            check($sformatf("stall_ena_k%0d", k), 32'(sh_ena),
                  32'(k == 2 || k == 3 || k == 7 || k == 8));
            check($sformatf("stall_done_k%0d", k), 32'(word_done), 32'(k == 8));
        end
        wait_idle("stall");

        // Backpressure: FSM held in SHIFT by stall while words 1..5 are offered
        @(posedge clk);
        #1;
        stall = 1'b1;
        accepted = 0;
        push_word(4'hA);
        full_seen = 0;
        fork
            begin
                for (int w = 1; w <= 5; w++) push_word(4'(w));
            end
            begin
                for (int t = 0; t < 100 && !full_seen; t++) begin
                    @(negedge clk);
                    if (fifo_count == 4) full_seen = 1;
                end
                check("bp_full_reached", 32'(full_seen), 1);
                for (int t = 0; t < 3; t++) begin
                    check("bp_in_ready_low", 32'(in_ready), 0);
                    check("bp_accepted", 32'(accepted), 5);
                    @(negedge clk);
                end
                #2 stall = 1'b0;
            end
        join
        check("bp_all_accepted", 32'(accepted), 6);
        wait_idle("bp");

        // Reset mid-operation with words queued
        @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) push_word(4'($urandom));
        begin
            bit seen;
            seen = 0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                if (sh_ena) seen = 1;
            end
            check("rstmid_in_shift", 32'(seen), 1);
        end
        check("rstmid_queued", 32'(fifo_count), 2);
        #2 areset_n = 1'b0;
        #1 chk_reset_outputs("rstmid");
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 areset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rstmid_no_load", 32'(sh_load), 0);
            check("rstmid_idle", 32'(busy), 0);
        end
        @(posedge clk);
        #1;
        push_word(4'($urandom));
        wait_idle("rstmid_after");

        // Random traffic with random stall, including FIFO wrap-around
        rs_done = 0;
        fork
            begin
                for (int w = 0; w < 40; w++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    push_word(4'($urandom));
                end
                rs_done = 1;
            end
            begin
                while (!rs_done) begin
                    @(posedge clk);
                    #1;
                    stall = ($urandom_range(0, 3) == 0);
                end
                stall = 1'b0;
            end
        join
        wait_idle("random");
        check("random_word_closed", 32'(in_word), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/shift4_feeder.md
SHIFT4_FEEDER -- requirements
Module: shift4_feeder

Interface
REQ-001 SHALL have parameter size, default 4, giving the data word width and the shifts per word.
REQ-002 SHALL have parameter DEPTH, default 4, giving the input FIFO entry count (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port areset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream word valid.
REQ-006 SHALL have port in_data, input, size, upstream word.
REQ-007 SHALL have port in_ready, output, 1, FIFO can accept a word.
REQ-008 SHALL have port stall, input, 1, pause shifting.
REQ-009 SHALL have port sh_load, output, 1, load strobe to the downstream Shift4.
REQ-010 SHALL have port sh_ena, output, 1, shift enable to the downstream Shift4.
REQ-011 SHALL have port sh_data, output, size, parallel word to the downstream Shift4.
REQ-012 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-013 SHALL have port word_done, output, 1, one-cycle pulse on the last shift of a word.
REQ-014 SHALL have port fifo_count, output, $clog2(DEPTH)+1, FIFO occupancy.

Function
REQ-015 SHALL implement a DEPTH-entry FIFO; push occurs on an edge where in_valid && in_ready.
REQ-016 SHALL drive in_ready = (fifo_count != DEPTH), combinationally from the registered count.
REQ-017 SHALL use three states: IDLE, LOAD, SHIFT; sh_load, sh_ena, sh_data, busy and word_done SHALL be registered.
REQ-018 IDLE: on an edge with fifo_count != 0, SHALL pop the head into sh_data, set sh_load=1 and enter LOAD.
REQ-019 LOAD: SHALL hold sh_load=1 for exactly one cycle, then clear sh_load, set sh_ena=1 (if stall=0), clear the shift counter and enter SHIFT.
REQ-020 SHIFT: each cycle with stall=0, sh_ena=1 and the counter increments; with stall=1, sh_ena=0 and the counter holds.
REQ-021 SHALL issue exactly size enabled cycles per word; word_done=1 during the size-th enabled cycle.
REQ-022 After the size-th enabled cycle: if fifo_count != 0, SHALL pop and enter LOAD directly (no IDLE cycle); else enter IDLE.
REQ-023 sh_load and sh_ena SHALL never be high in the same cycle.
REQ-024 sh_data SHALL hold its value from the pop until the next pop.
REQ-025 Push and pop on the same edge SHALL leave fifo_count unchanged and preserve order; a push to an empty FIFO is not poppable before the following edge.
REQ-026 Pointers SHALL wrap modulo DEPTH; no word is dropped or duplicated across wrap-around.
REQ-027 stall SHALL not affect LOAD or FIFO push; stall in IDLE SHALL have no effect.

Reset
REQ-028 areset_n=0 SHALL immediately force IDLE, fifo_count=0, pointers=0, counter=0, sh_load=0, sh_ena=0, sh_data=0, busy=0, word_done=0.
REQ-029 Reset mid-word SHALL discard the in-flight word and all FIFO contents; in_ready=1 while in reset.
REQ-030 Outputs SHALL leave reset values only on the first clk edge after areset_n rises.

Verification
REQ-031 Reset: assert areset_n=0 mid-cycle -> all outputs 0 and in_ready=1 without a clock edge.
REQ-032 Single word: push 4'b1011 at edge N -> sh_load=1 with sh_data=4'b1011 after edge N+1; sh_ena=1 for 4 cycles after edges N+2..N+5; word_done after edge N+5; busy=0 after edge N+6.
REQ-033 Back-to-back: push 4'b0001, 4'b1110 -> second sh_load immediately follows first word's word_done cycle, no IDLE gap, 10 busy cycles total.
REQ-034 Backpressure: hold in_valid=1 with FSM stalled, 5 words offered -> 4 accepted, in_ready=0 at fifo_count=4, fifth accepted on the first pop edge; output order 1..5.
REQ-035 Stall: stall=1 for 3 cycles after the second enabled shift -> sh_ena=0 for those 3 cycles; still exactly 4 enabled cycles; word_done delayed by 3.
REQ-036 Reset mid-operation: areset_n=0 during SHIFT with 2 words queued -> fifo_count=0, IDLE; after release no sh_load until a new push.
